// File: rtl/adc_reader_pkg.sv
// Shared widths and helpers for the ADC result reader.
package adc_reader_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DROP_W_DEF = 8;
    localparam logic [DROP_W_DEF-1:0] DROP_MAX = '1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// DEPTH x DATA_W result FIFO: head is read straight from storage, level kept as an explicit counter.
module adc_result_fifo
    import adc_reader_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    localparam int PW    = clog2(DEPTH),
    localparam int LW    = clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [LW-1:0]     level_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the write lands in, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/adc_result_reader.sv
// Captures ADC results on conv_finished rising edges into a FIFO with drop accounting.
// Define ADC_RESULT_READER_SYNC_EN to put a 2-flop synchronizer on conv_finished_in.
module adc_result_reader
    import adc_reader_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DROP_W = DROP_W_DEF,
    localparam int LW    = clog2(DEPTH + 1)
) (
    input  logic              clk_dig_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic              clear_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              conv_finished_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [LW-1:0]     level_out,
    output logic              overflow_out,
    output logic [DROP_W-1:0] drop_cnt_out,
    output logic [15:0]       sample_cnt_out
);

    logic cf_s, cf_prev_q, edge_det;
    logic push_req, pop, full, empty, accept, drop;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [15:0]       smp_q, smp_d;

`ifdef ADC_RESULT_READER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_dig_in or posedge rst_in) begin
        if (rst_in) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], conv_finished_in};
    end
    assign cf_s = sync_q[1];
`else
    assign cf_s = conv_finished_in;
`endif

    // History resets high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk_dig_in or posedge rst_in) begin
        if (rst_in) cf_prev_q <= 1'b1;
        else        cf_prev_q <= cf_s;
    end

    assign edge_det = cf_s & ~cf_prev_q;
    assign push_req = edge_det & enable_in & ~clear_in;
    assign pop      = ~empty & ready_in;
    assign accept   = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    adc_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk_i   (clk_dig_in),
        .rst_i   (rst_in),
        .clr_i   (clear_in),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i (result_in),
        .rdata_o (data_out),
        .level_o (level_out),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        smp_d  = smp_q;
        if (clear_in) begin
            ovf_d  = 1'b0;
            drop_d = '0;
            smp_d  = '0;
        end else begin
            if (accept) smp_d = smp_q + 16'd1;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_dig_in or posedge rst_in) begin
        if (rst_in) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
            smp_q  <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            smp_q  <= smp_d;
        end
    end

    assign valid_out      = ~empty;
    assign overflow_out   = ovf_q;
    assign drop_cnt_out   = drop_q;
    assign sample_cnt_out = smp_q;

endmodule
